// File: rtl/task1.sv
// Unsigned sequential shift-add multiplier (IDLE/BUSY/DONE), O = A*B with a finish flag F.
// Optional build macro TASK1_EARLY_DONE_EN ends BUSY once the remaining multiplier bits are zero.
module task1 #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] O,
  output logic           F
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [2*N-1:0] r_a;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_o;
  logic [2*N-1:0] w_acc_next;
  logic [N-1:0]   r_b;
  logic [CW-1:0]  r_cnt;
  logic           r_f;
  logic           w_last;

  assign O = r_o;
  assign F = r_f;

  // Partial product for this iteration; r_a is pre-shifted by the iteration index
  always_comb begin
    w_acc_next = r_acc;
    if (r_b[0]) begin
      w_acc_next = r_acc + r_a;
    end else begin
      w_acc_next = r_acc;
    end
  end

  // Final iteration detect
  always_comb begin
`ifdef TASK1_EARLY_DONE_EN
    w_last = (r_cnt == CW'(1)) || ((r_b >> 1) == '0);
`else
    w_last = (r_cnt == CW'(1));
`endif
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = BUSY; else w_next = IDLE;
      BUSY:    if (w_last) w_next = DONE; else w_next = BUSY;
      DONE:    if (start) w_next = DONE; else w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath and registered outputs; O only moves on completion or reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_o   <= '0;
      r_f   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= {{N{1'b0}}, A};
            r_b   <= B;
            r_acc <= '0;
            r_cnt <= CW'(N);
          end
        end
        BUSY: begin
          r_acc <= w_acc_next;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_o <= w_acc_next;
            r_f <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            r_f <= 1'b0;
          end
        end
        default: begin
          r_f <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_task1.sv
// Scoreboard bench for task1: driver pushes expected product and completion cycle,
// a negedge monitor pops and compares when F rises and checks O stability otherwise.
module tb_task1;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   A = '0;
  logic [N-1:0]   B = '0;
  logic [2*N-1:0] O;
  logic           F;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];
  int due_q[$];
  int hold_o = 0;
  logic f_prev = 1'b0;

  task1 #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .O(O), .F(F)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier iterations expected for operand b
  function automatic int iters(input int b);
`ifdef TASK1_EARLY_DONE_EN
    int n;
    int v;
    n = 0;
    v = b;
    while (v != 0) begin
      n++;
      v = v >> 1;
    end
    if (n < 1) n = 1;
    return n;
`else
    return N;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare result when F rises, otherwise O must hold
  always @(negedge clk) begin
    if (!reset) begin
      hold_o = 0;
      f_prev = 1'b0;
    end else begin
      if (F && !f_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_F", 1, 0);
        end else begin
          hold_o = exp_q.pop_front();
          chk("product", int'(O), hold_o);
          chk("latency", cyc, due_q.pop_front());
        end
      end else begin
        chk("O_hold", int'(O), hold_o);
      end
      f_prev = F;
    end
  end

  task automatic do_op(input int a, input int b);
    bit seen;
    int prod;
    prod = a * b;
    @(posedge clk); #1;
    A = a[N-1:0];
    B = b[N-1:0];
    start = 1'b1;
    exp_q.push_back(prod);
    due_q.push_back(cyc + 1 + iters(b));
    @(posedge clk); #1;
    A = N'($urandom);
    B = N'($urandom);
    seen = F;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      seen = F;
    end
    if (!seen) begin
      chk("F_timeout", 0, 1);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
    A = 4'd3;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("F_held", int'(F), 1);
      chk("O_held_start", int'(O), prod);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("F_clear", int'(F), 0);
    chk("O_after_clear", int'(O), prod);
  endtask

  initial begin
    A = 4'd15;
    B = 4'd12;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_O", int'(O), 0);
    chk("rst_F", int'(F), 0);
    reset = 1'b1;
    do_op(15, 12);
    do_op(15, 15);
    do_op(0, 9);
    do_op(9, 1);
    do_op(9, 0);

    // Abort during the second BUSY cycle
    @(posedge clk); #1;
    A = 4'd7;
    B = 4'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("abort_O", int'(O), 0);
    chk("abort_F", int'(F), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_F", int'(F), 0);
    chk("idle_O", int'(O), 0);

    for (int t = 0; t < 20; t++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    do_op(15, 15);
    do_op(1, 8);

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
